// File: rtl/imm_gen_pipe.sv
`timescale 1ns/1ps
// Registered RISC-V immediate generator (I/S/B/U/J, optional CSR zimm via IMM_GEN_ZIMM_EN).
// One-cycle latency. A 2-entry output/skid buffer lets in_ready come straight from a flop.
module imm_gen_pipe #(
  parameter int XLEN      = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          Inst,
  input  logic [2:0]           ImmSrc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      ImmExt,
  output logic                 fmt_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  logic [XLEN-1:0] dec_imm;
  logic            dec_err;

  // The opcode field never contributes to any immediate.
  logic unused_opcode;
  assign unused_opcode = ^Inst[6:0];

  always_comb begin
    dec_imm = '0;
    dec_err = 1'b0;
    case (ImmSrc)
      3'b000: dec_imm = sext32({{20{Inst[31]}}, Inst[31:20]});
      3'b001: dec_imm = sext32({{20{Inst[31]}}, Inst[31:25], Inst[11:7]});
      3'b010: dec_imm = sext32({{19{Inst[31]}}, Inst[31], Inst[7], Inst[30:25], Inst[11:8], 1'b0});
      3'b011: dec_imm = sext32({Inst[31:12], 12'b0});
      3'b100: dec_imm = sext32({{11{Inst[31]}}, Inst[31], Inst[19:12], Inst[20], Inst[30:21], 1'b0});
`ifdef IMM_GEN_ZIMM_EN
      3'b101: dec_imm = {{(XLEN-5){1'b0}}, Inst[19:15]};
`else
      3'b101: dec_err = 1'b1;
`endif
      default: dec_err = 1'b1;
    endcase
  end

  logic            main_vld, main_err;
  logic [XLEN-1:0] main_imm;
  logic            skid_free, skid_err;
  logic [XLEN-1:0] skid_imm;

  logic accept, drain;
  assign accept = in_valid & skid_free;
  assign drain  = main_vld & out_ready;

  // skid_free is the inverted skid valid bit, kept as its own flop so in_ready has no logic in front of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld  <= 1'b0;
      main_imm  <= '0;
      main_err  <= 1'b0;
      skid_free <= 1'b1;
      skid_imm  <= '0;
      skid_err  <= 1'b0;
      err_count <= '0;
    end else begin
      if (drain && !skid_free) begin
        main_imm  <= skid_imm;
        main_err  <= skid_err;
        skid_free <= 1'b1;
      end else if (accept && (!main_vld || drain)) begin
        main_vld <= 1'b1;
        main_imm <= dec_imm;
        main_err <= dec_err;
      end else if (accept) begin
        skid_free <= 1'b0;
        skid_imm  <= dec_imm;
        skid_err  <= dec_err;
      end else if (drain) begin
        main_vld <= 1'b0;
      end

      if (accept && dec_err && (err_count != {ERR_CNT_W{1'b1}}))
        err_count <= err_count + 1'b1;
    end
  end

  assign in_ready  = skid_free;
  assign out_valid = main_vld;
  assign ImmExt    = main_imm;
  assign fmt_err   = main_err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
`timescale 1ns/1ps
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] Inst;
  logic [2:0]  ImmSrc;

  logic        rdy32, vld32, err32;
  logic [31:0] imm32;
  logic [7:0]  cnt32;
  logic        rdy64, vld64, err64;
  logic [63:0] imm64;
  logic [7:0]  cnt64;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .ERR_CNT_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .Inst(Inst), .ImmSrc(ImmSrc), .out_valid(vld32), .out_ready(out_ready),
    .ImmExt(imm32), .fmt_err(err32), .err_count(cnt32)
  );

  imm_gen_pipe #(.XLEN(64), .ERR_CNT_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
    .Inst(Inst), .ImmSrc(ImmSrc), .out_valid(vld64), .out_ready(out_ready),
    .ImmExt(imm64), .fmt_err(err64), .err_count(cnt64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] i, input logic [2:0] s);
    Inst     = i;
    ImmSrc   = s;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    Inst      = 32'hFFFF_FFFF;
    ImmSrc    = 3'b111;
    tick(); tick(); tick();
    chk("rst_out_valid", vld32, 0);
    chk("rst_immext", imm32, 0);
    chk("rst_fmt_err", err32, 0);
    chk("rst_err_count", cnt32, 0);
    chk("rst_in_ready", rdy32, 1);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    chk("post_rst_out_valid", vld32, 0);

    send(32'hFFF0_0093, 3'b000);
    chk("i_valid", vld32, 1);
    chk("i_imm", imm32, 32'hFFFF_FFFF);
    chk("i_err", err32, 0);
    chk("i_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);

    send(32'h00A1_2223, 3'b001);
    chk("s_imm", imm32, 32'h0000_0004);

    send(32'hFE00_0EE3, 3'b010);
    chk("b_imm", imm32, 32'hFFFF_FFFC);

    send(32'h1234_5037, 3'b011);
    chk("u_imm", imm32, 32'h1234_5000);

    send(32'h8000_0037, 3'b011);
    chk("u_imm32_neg", imm32, 32'h8000_0000);
    chk("u_imm64_neg", imm64, 64'hFFFF_FFFF_8000_0000);

    send(32'h0080_006F, 3'b100);
    chk("j_imm", imm32, 32'h0000_0008);

    send(32'hFFFF_FFFF, 3'b111);
    exp_cnt = 1;
    chk("ill7_imm", imm32, 0);
    chk("ill7_err", err32, 1);
    chk("ill7_cnt", cnt32, exp_cnt);
    chk("ill7_err64", err64, 1);

    send(32'h1234_5678, 3'b110);
    exp_cnt = 2;
    chk("ill6_err", err32, 1);
    chk("ill6_cnt", cnt32, exp_cnt);

    send(32'h0001_D073, 3'b101);
`ifdef IMM_GEN_ZIMM_EN
    chk("z_imm", imm32, 3);
    chk("z_err", err32, 0);
    chk("z_imm64", imm64, 3);
`else
    exp_cnt = 3;
    chk("z_imm", imm32, 0);
    chk("z_err", err32, 1);
`endif
    chk("z_cnt", cnt32, exp_cnt);
    tick();
    chk("idle_out_valid", vld32, 0);

    // Backpressure: A to main, B to skid, C stalled until the pipe drains.
    out_ready = 1'b0;
    Inst = 32'h0010_0093; ImmSrc = 3'b000; in_valid = 1'b1;
    tick();
    chk("bp_a_valid", vld32, 1);
    chk("bp_a_imm", imm32, 1);
    chk("bp_a_ready", rdy32, 1);
    Inst = 32'h0020_0093;
    tick();
    chk("bp_b_ready", rdy32, 0);
    chk("bp_b_ready64", rdy64, 0);
    chk("bp_hold_a", imm32, 1);
    Inst = 32'h0030_0093;
    tick();
    chk("bp_c_stalled", rdy32, 0);
    chk("bp_stable_a", imm32, 1);
    out_ready = 1'b1;
    tick();
    chk("bp_b_out", imm32, 2);
    chk("bp_b_valid", vld32, 1);
    chk("bp_ready_back", rdy32, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_c_out", imm32, 3);
    chk("bp_c_valid", vld32, 1);
    tick();
    chk("bp_empty", vld32, 0);

    // 300 back-to-back illegal beats at full throughput.
    Inst = 32'h0; ImmSrc = 3'b110; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 99) chk("sat_mid_cnt", cnt32, exp_cnt + 100);
    end
    in_valid = 1'b0;
    chk("sat_cnt", cnt32, 255);
    chk("sat_cnt64", cnt64, 255);
    chk("sat_ready", rdy32, 1);
    chk("sat_valid", vld32, 1);
    tick();
    chk("sat_drained", vld32, 0);
    chk("sat_hold", cnt32, 255);

    // Reset with both entries occupied.
    out_ready = 1'b0;
    Inst = 32'h0010_0093; ImmSrc = 3'b000; in_valid = 1'b1;
    tick();
    Inst = 32'h0020_0093;
    tick();
    in_valid = 1'b0;
    chk("mr_full_ready", rdy32, 0);
    chk("mr_full_valid", vld32, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", vld32, 0);
    chk("mr_ready", rdy32, 1);
    chk("mr_cnt", cnt32, 0);
    chk("mr_imm", imm32, 0);
    chk("mr_valid64", vld64, 0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("mr_no_stale1", vld32, 0);
    tick();
    chk("mr_no_stale2", vld32, 0);
    chk("mr_ready_after", rdy32, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
